// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// pipe_pkg : opcode constants, bubble encoding, stage record and FSM states.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam logic [3:0] OP_BRANCH = 4'b0010;
  localparam logic [3:0] OP_SWOP   = 4'b0011;
  localparam logic [3:0] OP_ALUI   = 4'b0100;
  localparam logic [3:0] OP_LWOP   = 4'b0111;
  localparam logic [3:0] OP_ALUR   = 4'b1100;
  localparam logic [3:0] OP_CMPR   = 4'b1101;

  // A never-taken branch with no register fields doubles as the bubble.
  localparam logic [3:0] BUBBLE_OP   = OP_BRANCH;
  localparam logic [3:0] BUBBLE_FUNC = 4'b0011;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } stage_t;

  localparam stage_t BUBBLE = '{op: BUBBLE_OP, func: BUBBLE_FUNC,
                                rd: 4'd0, rs1: 4'd0, rs2: 4'd0};

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FREEZE  = 2'd2
  } seq_state_e;

  function automatic logic rs2_used(input logic [3:0] op);
    return (op == OP_ALUR) || (op == OP_CMPR) || (op == OP_SWOP) || (op == OP_BRANCH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_op_sequencer_if.sv
//------------------------------------------------------------------------------
// pipe_op_sequencer_if : fetch inputs, pipeline controls and per-stage outputs.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_op_sequencer_if;

  logic [3:0]  IF_op;
  logic [3:0]  IF_func;
  logic [3:0]  IF_rd;
  logic [3:0]  IF_rs1;
  logic [3:0]  IF_rs2;
  logic        br_taken;
  logic        mem_busy;
  logic [3:0]  DEC_op;
  logic [3:0]  DEC_func;
  logic [3:0]  EX_op;
  logic [3:0]  EX_func;
  logic [3:0]  ME_op;
  logic [3:0]  ME_func;
  logic [3:0]  WB_op;
  logic [3:0]  WB_func;
  logic        pc_hold;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output IF_op, IF_func, IF_rd, IF_rs1, IF_rs2, br_taken, mem_busy,
    input  DEC_op, DEC_func, EX_op, EX_func, ME_op, ME_func, WB_op, WB_func,
    input  pc_hold, stall_cnt, flush_cnt
  );

  modport slave (
    input  IF_op, IF_func, IF_rd, IF_rs1, IF_rs2, br_taken, mem_busy,
    output DEC_op, DEC_func, EX_op, EX_func, ME_op, ME_func, WB_op, WB_func,
    output pc_hold, stall_cnt, flush_cnt
  );

endinterface

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
//------------------------------------------------------------------------------
// pipe_stage_reg : one pipeline stage record, priority bubble > hold > load.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
(
  input  wire    clk,
  input  wire    reset_n,
  input  wire    load,
  input  wire    hold,
  input  wire    bubble,
  input  stage_t d,
  output stage_t q
);

  stage_t stage_d;
  stage_t stage_q;

  always_comb begin
    stage_d = stage_q;
    if (bubble) begin
      stage_d = BUBBLE;
    end else if (hold) begin
      stage_d = stage_q;
    end else if (load) begin
      stage_d = d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q;

endmodule

`default_nettype wire

// File: rtl/pipe_op_sequencer.sv
//------------------------------------------------------------------------------
// pipe_op_sequencer : DEC/EX/ME/WB op sequencer with load-use stall,
//                     branch flush, memory freeze and saturating event counters.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_op_sequencer
  import pipe_pkg::*;
(
  input  wire                 clk,
  input  wire                 reset_n,
  pipe_op_sequencer_if.slave  bus
);

  localparam int N_STAGES = 4;
  localparam int S_DEC    = 0;
  localparam int S_EX     = 1;
  localparam int S_ME     = 2;
  localparam int S_WB     = 3;

  stage_t               if_rec;
  stage_t               stage_in [N_STAGES];
  stage_t               stage_q  [N_STAGES];
  logic [N_STAGES-1:0]  st_load;
  logic [N_STAGES-1:0]  st_hold;
  logic [N_STAGES-1:0]  st_bubble;

  seq_state_e  state_d, state_q;
  logic [15:0] stall_cnt_d, stall_cnt_q;
  logic [15:0] flush_cnt_d, flush_cnt_q;
  logic        pc_hold;
  logic        stall_inc;
  logic        flush_inc;
  logic        dec_reads_ex_rd;
  logic        hazard;

  assign if_rec = '{op: bus.IF_op, func: bus.IF_func, rd: bus.IF_rd,
                    rs1: bus.IF_rs1, rs2: bus.IF_rs2};

  for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign stage_in[i] = if_rec;
    end else begin : g_next
      assign stage_in[i] = stage_q[i-1];
    end

    pipe_stage_reg u_stage_reg (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (st_load[i]),
      .hold   (st_hold[i]),
      .bubble (st_bubble[i]),
      .d      (stage_in[i]),
      .q      (stage_q[i])
    );
  end

  assign dec_reads_ex_rd = (stage_q[S_EX].rd == stage_q[S_DEC].rs1) ||
                           (rs2_used(stage_q[S_DEC].op) &&
                            (stage_q[S_EX].rd == stage_q[S_DEC].rs2));

  // EX already holds the inserted bubble during LDSTALL, so no re-detection there.
  assign hazard = (state_q != ST_LDSTALL) &&
                  (stage_q[S_EX].op == OP_LWOP) &&
                  (stage_q[S_EX].rd != 4'd0) &&
                  dec_reads_ex_rd;

  always_comb begin
    state_d   = ST_RUN;
    st_load   = '1;
    st_hold   = '0;
    st_bubble = '0;
    pc_hold   = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (bus.mem_busy) begin
      state_d = ST_FREEZE;
      st_hold = '1;
      pc_hold = 1'b1;
    end else if (bus.br_taken) begin
      st_bubble[S_DEC] = 1'b1;
      st_bubble[S_EX]  = 1'b1;
      flush_inc        = 1'b1;
    end else if (hazard) begin
      state_d          = ST_LDSTALL;
      st_hold[S_DEC]   = 1'b1;
      st_bubble[S_EX]  = 1'b1;
      pc_hold          = 1'b1;
      stall_inc        = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.DEC_op    = stage_q[S_DEC].op;
  assign bus.DEC_func  = stage_q[S_DEC].func;
  assign bus.EX_op     = stage_q[S_EX].op;
  assign bus.EX_func   = stage_q[S_EX].func;
  assign bus.ME_op     = stage_q[S_ME].op;
  assign bus.ME_func   = stage_q[S_ME].func;
  assign bus.WB_op     = stage_q[S_WB].op;
  assign bus.WB_func   = stage_q[S_WB].func;
  assign bus.pc_hold   = pc_hold;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_op_sequencer.sv
//------------------------------------------------------------------------------
// tb_pipe_op_sequencer : vector table for hazard/flush decisions, scoreboard
//                        for straight-line flow, hand sequences for corner cases.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_op_sequencer;
  import pipe_pkg::*;

  localparam logic [3:0] OP_X = 4'b0001;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_op_sequencer_if bus();

  pipe_op_sequencer dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    string      name;
    logic [3:0] a_op;
    logic [3:0] a_rd;
    logic [3:0] b_op;
    logic [3:0] b_rs1;
    logic [3:0] b_rs2;
    logic       br;
    logic       exp_hold;
    logic [3:0] exp_dec_op;
    logic [3:0] exp_ex_op;
    logic [15:0] exp_stall;
    logic [15:0] exp_flush;
  } vec_t;

  typedef struct {
    int         due;
    logic [3:0] op;
    logic [3:0] func;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_if(input logic [3:0] op, input logic [3:0] func,
                          input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
    bus.IF_op   = op;
    bus.IF_func = func;
    bus.IF_rd   = rd;
    bus.IF_rs1  = rs1;
    bus.IF_rs2  = rs2;
  endtask

  task automatic do_reset();
    tick();
    reset_n      = 1'b0;
    bus.br_taken = 1'b0;
    bus.mem_busy = 1'b0;
    drive_if(BUBBLE_OP, BUBBLE_FUNC, 4'd0, 4'd0, 4'd0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] a_op, input logic [3:0] a_rd,
                              input logic [3:0] b_op, input logic [3:0] b_rs1, input logic [3:0] b_rs2,
                              input logic br, input logic exp_hold, input logic [3:0] exp_dec_op,
                              input logic [3:0] exp_ex_op, input logic [15:0] exp_stall,
                              input logic [15:0] exp_flush);
    vec_t v;
    v.name = name; v.a_op = a_op; v.a_rd = a_rd; v.b_op = b_op; v.b_rs1 = b_rs1;
    v.b_rs2 = b_rs2; v.br = br; v.exp_hold = exp_hold; v.exp_dec_op = exp_dec_op;
    v.exp_ex_op = exp_ex_op; v.exp_stall = exp_stall; v.exp_flush = exp_flush;
    return v;
  endfunction

  // Producer A reaches EX while consumer B sits in DEC; br is applied in that cycle.
  task automatic run_vec(input vec_t v);
    do_reset();
    drive_if(v.a_op, 4'h0, v.a_rd, 4'd0, 4'd0);
    tick();
    drive_if(v.b_op, 4'h1, 4'd1, v.b_rs1, v.b_rs2);
    tick();
    drive_if(OP_X, 4'hA, 4'd2, 4'd0, 4'd0);
    bus.br_taken = v.br;
    @(negedge clk);
    check({v.name, "_pc_hold"}, 32'(bus.pc_hold), 32'(v.exp_hold));
    tick();
    bus.br_taken = 1'b0;
    @(negedge clk);
    check({v.name, "_dec_op"}, 32'(bus.DEC_op), 32'(v.exp_dec_op));
    check({v.name, "_ex_op"}, 32'(bus.EX_op), 32'(v.exp_ex_op));
    check({v.name, "_stall_cnt"}, 32'(bus.stall_cnt), 32'(v.exp_stall));
    check({v.name, "_flush_cnt"}, 32'(bus.flush_cnt), 32'(v.exp_flush));
  endtask

  task automatic check_all_bubble(input string name);
    check({name, "_dec"}, {bus.DEC_op, bus.DEC_func}, {BUBBLE_OP, BUBBLE_FUNC});
    check({name, "_ex"},  {bus.EX_op,  bus.EX_func},  {BUBBLE_OP, BUBBLE_FUNC});
    check({name, "_me"},  {bus.ME_op,  bus.ME_func},  {BUBBLE_OP, BUBBLE_FUNC});
    check({name, "_wb"},  {bus.WB_op,  bus.WB_func},  {BUBBLE_OP, BUBBLE_FUNC});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    bus.br_taken = 1'b0;
    bus.mem_busy = 1'b0;
    drive_if(BUBBLE_OP, BUBBLE_FUNC, 4'd0, 4'd0, 4'd0);

    vecs[0] = mk("lu_alur_rs2", OP_LWOP, 4'd3, OP_ALUR, 4'd1, 4'd3, 1'b0, 1'b1, OP_ALUR,   BUBBLE_OP, 16'd1, 16'd0);
    vecs[1] = mk("lu_rd0",      OP_LWOP, 4'd0, OP_ALUR, 4'd0, 4'd0, 1'b0, 1'b0, OP_X,      OP_ALUR,   16'd0, 16'd0);
    vecs[2] = mk("lu_alui_rs2", OP_LWOP, 4'd3, OP_ALUI, 4'd1, 4'd3, 1'b0, 1'b0, OP_X,      OP_ALUI,   16'd0, 16'd0);
    vecs[3] = mk("lu_alui_rs1", OP_LWOP, 4'd3, OP_ALUI, 4'd3, 4'd0, 1'b0, 1'b1, OP_ALUI,   BUBBLE_OP, 16'd1, 16'd0);
    vecs[4] = mk("lu_sw_rs2",   OP_LWOP, 4'd3, OP_SWOP, 4'd0, 4'd3, 1'b0, 1'b1, OP_SWOP,   BUBBLE_OP, 16'd1, 16'd0);
    vecs[5] = mk("flush_win",   OP_LWOP, 4'd3, OP_ALUR, 4'd1, 4'd3, 1'b1, 1'b0, BUBBLE_OP, BUBBLE_OP, 16'd0, 16'd1);
    vecs[6] = mk("no_load",     OP_ALUI, 4'd3, OP_ALUR, 4'd1, 4'd3, 1'b0, 1'b0, OP_X,      OP_ALUR,   16'd0, 16'd0);
    vecs[7] = mk("lu_br_rs2",   OP_LWOP, 4'd3, OP_BRANCH, 4'd0, 4'd3, 1'b0, 1'b1, OP_BRANCH, BUBBLE_OP, 16'd1, 16'd0);
    vecs[8] = mk("lu_cmpr_rs2", OP_LWOP, 4'd3, OP_CMPR, 4'd2, 4'd3, 1'b0, 1'b1, OP_CMPR,   BUBBLE_OP, 16'd1, 16'd0);
    vecs[9] = mk("lu_other_rd", OP_LWOP, 4'd5, OP_CMPR, 4'd2, 4'd3, 1'b0, 1'b0, OP_X,      OP_CMPR,   16'd0, 16'd0);

    // Reset state
    do_reset();
    @(negedge clk);
    check_all_bubble("rst");
    check("rst_pc_hold", 32'(bus.pc_hold), 32'd0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);

    // Straight-line flow through the scoreboard
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 4) begin
        drive_if(OP_ALUI, 4'(k + 1), 4'(k + 1), 4'd0, 4'd0);
        sb.push_back('{due: cyc + 4, op: OP_ALUI, func: 4'(k + 1)});
      end else begin
        drive_if(BUBBLE_OP, BUBBLE_FUNC, 4'd0, 4'd0, 4'd0);
      end
      @(negedge clk);
      check("sl_pc_hold", 32'(bus.pc_hold), 32'd0);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("sl_wb", {bus.WB_op, bus.WB_func}, {e.op, e.func});
      end else begin
        check("sl_wb_idle", 32'(bus.WB_op), 32'(BUBBLE_OP));
      end
      tick();
    end
    check("sl_drained", 32'(sb.size()), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Load-use: bubble visible in EX for one cycle, then the consumer follows
    do_reset();
    drive_if(OP_LWOP, 4'h0, 4'd3, 4'd0, 4'd0);
    tick();
    drive_if(OP_ALUR, 4'h5, 4'd1, 4'd1, 4'd3);
    tick();
    drive_if(OP_X, 4'hA, 4'd2, 4'd0, 4'd0);
    @(negedge clk);
    check("lu_hold_cycle", 32'(bus.pc_hold), 32'd1);
    tick();
    @(negedge clk);
    check("lu_ex_bubble", {bus.EX_op, bus.EX_func}, {BUBBLE_OP, BUBBLE_FUNC});
    check("lu_hold_once", 32'(bus.pc_hold), 32'd0);
    check("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    tick();
    @(negedge clk);
    check("lu_ex_alur", {bus.EX_op, bus.EX_func}, {OP_ALUR, 4'h5});
    check("lu_stall_cnt_final", 32'(bus.stall_cnt), 32'd1);

    // Freeze over a pending hazard with a concurrent (ignored) branch
    do_reset();
    drive_if(OP_LWOP, 4'h0, 4'd3, 4'd0, 4'd0);
    tick();
    drive_if(OP_ALUR, 4'h5, 4'd1, 4'd1, 4'd3);
    tick();
    drive_if(OP_X, 4'hA, 4'd2, 4'd0, 4'd0);
    bus.mem_busy = 1'b1;
    bus.br_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("frz_pc_hold", 32'(bus.pc_hold), 32'd1);
      check("frz_dec", 32'(bus.DEC_op), 32'(OP_ALUR));
      check("frz_ex", 32'(bus.EX_op), 32'(OP_LWOP));
      check("frz_me", 32'(bus.ME_op), 32'(BUBBLE_OP));
      check("frz_wb", 32'(bus.WB_op), 32'(BUBBLE_OP));
      check("frz_cnts", {bus.stall_cnt, bus.flush_cnt}, 32'd0);
      tick();
    end
    bus.mem_busy = 1'b0;
    bus.br_taken = 1'b0;
    @(negedge clk);
    check("frz_rel_hold", 32'(bus.pc_hold), 32'd1);
    tick();
    @(negedge clk);
    check("frz_rel_stall", 32'(bus.stall_cnt), 32'd1);
    check("frz_rel_flush", 32'(bus.flush_cnt), 32'd0);
    check("frz_rel_ex", 32'(bus.EX_op), 32'(BUBBLE_OP));
    check("frz_rel_me", 32'(bus.ME_op), 32'(OP_LWOP));
    tick();
    @(negedge clk);
    check("frz_rel_ex_alur", 32'(bus.EX_op), 32'(OP_ALUR));

    // Reset asserted in the LDSTALL cycle
    do_reset();
    drive_if(OP_LWOP, 4'h0, 4'd3, 4'd0, 4'd0);
    tick();
    drive_if(OP_ALUR, 4'h5, 4'd1, 4'd1, 4'd3);
    tick();
    drive_if(OP_X, 4'hA, 4'd2, 4'd0, 4'd0);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_all_bubble("rst_ldstall");
    check("rst_ldstall_pc_hold", 32'(bus.pc_hold), 32'd0);
    check("rst_ldstall_stall", 32'(bus.stall_cnt), 32'd0);
    tick();
    reset_n = 1'b1;
    drive_if(OP_ALUI, 4'h7, 4'd1, 4'd0, 4'd0);
    @(negedge clk);
    check("post_rst_pc_hold", 32'(bus.pc_hold), 32'd0);
    check_all_bubble("post_rst");
    tick();
    @(negedge clk);
    check("post_rst_dec", {bus.DEC_op, bus.DEC_func}, {OP_ALUI, 4'h7});

    // Flush counter saturation
    do_reset();
    drive_if(BUBBLE_OP, BUBBLE_FUNC, 4'd0, 4'd0, 4'd0);
    bus.br_taken = 1'b1;
    repeat (65534) tick();
    @(negedge clk);
    check("sat_fffe", 32'(bus.flush_cnt), 32'hFFFE);
    tick();
    tick();
    @(negedge clk);
    check("sat_ffff", 32'(bus.flush_cnt), 32'hFFFF);
    tick();
    @(negedge clk);
    check("sat_hold", 32'(bus.flush_cnt), 32'hFFFF);
    check("sat_stall", 32'(bus.stall_cnt), 32'd0);
    bus.br_taken = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
